// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: state encoding and check-edge offset shared by the UART receive controller
package uart_rx_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_state_e;
    localparam int CE_OFFSET = 2;
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: serial pin, checker and deserializer signals around the receive controller
interface uart_rx_ctrl_if #(parameter int PRESCALE_WIDTH = 6);
    logic                      RX_IN, PAR_EN, sampled_bit, par_err, strt_glitch, stp_err;
    logic [PRESCALE_WIDTH-1:0] Prescale, edge_cnt;
    logic                      dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en;
    logic                      data_valid, PAR_ERR_FLAG, STP_ERR_FLAG;
    modport master (
        input  RX_IN, PAR_EN, Prescale, sampled_bit, par_err, strt_glitch, stp_err,
        output dat_samp_en, edge_cnt, strt_chk_en, par_chk_en, stp_chk_en, deser_en,
               data_valid, PAR_ERR_FLAG, STP_ERR_FLAG
    );
    modport slave (
        output RX_IN, PAR_EN, Prescale, sampled_bit, par_err, strt_glitch, stp_err,
        input  dat_samp_en, edge_cnt, strt_chk_en, par_chk_en, stp_chk_en, deser_en,
               data_valid, PAR_ERR_FLAG, STP_ERR_FLAG
    );
endinterface

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// edge_bit_counter: oversampling edge counter within a bit plus frame bit counter
module edge_bit_counter #(
    parameter int PW = 6,
    parameter int BW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [PW-1:0] prescale_i,
    output logic [PW-1:0] edge_cnt_o,
    output logic [BW-1:0] bit_cnt_o,
    output logic          bit_end_o
);
    logic [PW-1:0] edge_q, edge_d;
    logic [BW-1:0] bit_q, bit_d;
    always_comb begin
        bit_end_o = edge_q == prescale_i - PW'(1);
        edge_d    = clr_i ? '0 : !en_i ? edge_q : bit_end_o ? '0 : edge_q + PW'(1);
        bit_d     = clr_i ? '0 : (en_i && bit_end_o) ? bit_q + BW'(1) : bit_q;
    end
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    assign edge_cnt_o = edge_q;
    assign bit_cnt_o  = bit_q;
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer - start detect, bit timing, checker strobes, frame validation.
// Define UART_RX_ERR_FLAGS_EN for sticky PAR_ERR_FLAG/STP_ERR_FLAG; otherwise both are tied low.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic            CLK,
    input logic            RST,
    uart_rx_ctrl_if.master b
);
    localparam int BW = $clog2(DATA_WIDTH + 3);
    rx_state_e                 state_q;
    logic                      par_en_q, par_err_q, stp_err_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q, ce;
    logic [BW-1:0]             bit_cnt;
    logic                      at_ce, bit_end, start, abort, clr, good;

    // CE is the first edge where the sampler's majority vote is settled
    assign ce    = (prescale_q >> 1) + PRESCALE_WIDTH'(CE_OFFSET);
    assign at_ce = b.edge_cnt == ce;
    assign start = (state_q == IDLE || state_q == DONE) && !b.RX_IN;
    assign abort = state_q == START && at_ce && b.strt_glitch;
    assign clr   = state_q == IDLE || state_q == DONE || abort;
    assign good  = !par_err_q && !stp_err_q;

    edge_bit_counter #(.PW(PRESCALE_WIDTH), .BW(BW)) u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .en_i       (!clr),
        .clr_i      (clr),
        .prescale_i (prescale_q),
        .edge_cnt_o (b.edge_cnt),
        .bit_cnt_o  (bit_cnt),
        .bit_end_o  (bit_end)
    );

    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            state_q    <= IDLE;
            par_en_q   <= 1'b0;
            prescale_q <= '0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
        end else if (start) begin
            state_q    <= START;
            par_en_q   <= b.PAR_EN;
            prescale_q <= b.Prescale;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
        end else
            case (state_q)
                START:   if (abort) state_q <= IDLE; else if (bit_end) state_q <= DATA;
                DATA:    if (bit_end && bit_cnt == BW'(DATA_WIDTH)) state_q <= par_en_q ? PARITY : STOP;
                PARITY: begin
                    if (at_ce) par_err_q <= b.par_err;
                    if (bit_end) state_q <= STOP;
                end
                // leave at CE so a following start bit is never missed
                STOP: if (at_ce) begin
                    stp_err_q <= b.stp_err;
                    state_q   <= DONE;
                end
                default: state_q <= IDLE;
            endcase

    assign b.dat_samp_en = state_q != IDLE;
    assign b.strt_chk_en = state_q == START  && at_ce;
    assign b.deser_en    = state_q == DATA   && at_ce;
    assign b.par_chk_en  = state_q == PARITY && at_ce;
    assign b.stp_chk_en  = state_q == STOP   && at_ce;
    assign b.data_valid  = state_q == DONE   && good;

`ifdef UART_RX_ERR_FLAGS_EN
    logic par_flag_q, stp_flag_q;
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            par_flag_q <= 1'b0;
            stp_flag_q <= 1'b0;
        end else if (state_q == DONE) begin
            par_flag_q <= !good && (par_flag_q || par_err_q);
            stp_flag_q <= !good && (stp_flag_q || stp_err_q);
        end
    assign b.PAR_ERR_FLAG = par_flag_q;
    assign b.STP_ERR_FLAG = stp_flag_q;
`else
    assign b.PAR_ERR_FLAG = 1'b0;
    assign b.STP_ERR_FLAG = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for the UART receive frame sequencer
module tb_uart_rx_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_rx_ctrl_if #(.PRESCALE_WIDTH(6)) b ();
    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (.CLK(CLK), .RST(RST), .b(b));

    typedef struct {
        int         cyc;
        logic [4:0] v;
        int         e;
    } ev_t;
    ev_t q[$];
    int errors = 0;
    int checks = 0;
`ifdef UART_RX_ERR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    function automatic logic [4:0] strobes();
        return {b.strt_chk_en, b.deser_en, b.par_chk_en, b.stp_chk_en, b.data_valid};
    endfunction

    task automatic start(input int ps, input bit pe);
        b.RX_IN       = 1'b0;
        b.Prescale    = 6'(ps);
        b.PAR_EN      = pe;
        b.strt_glitch = 1'b0;
    endtask

    task automatic frame(input int ps, input bit pe, input logic [7:0] d, input bit gl, input bit perr,
                         input bit serr, input bit b2b, input int nps, input bit npe, input int abort_c);
        int ce, nb, cdone, last, bi;
        logic [4:0] obs;
        ev_t h;
        ce    = ps / 2 + 2;
        nb    = 9 + int'(pe);
        cdone = nb * ps + ce + 1;
        last  = gl ? ce + 1 : cdone;
        q.push_back('{ce, 5'b10000, ce});
        if (!gl) begin
            for (int k = 1; k <= 8; k++) q.push_back('{k * ps + ce, 5'b01000, ce});
            if (pe) q.push_back('{9 * ps + ce, 5'b00100, ce});
            q.push_back('{nb * ps + ce, 5'b00010, ce});
            q.push_back('{cdone, {4'b0000, !(pe && perr) && !serr}, -1});
        end
        for (int c = 0; c <= last; c++) begin
            @(posedge CLK); #1;
            if (c == abort_c) begin
                q.delete();
                return;
            end
            obs = strobes();
            checks++;
            if (q.size() > 0 && q[0].cyc == c) begin
                h = q.pop_front();
                if (obs !== h.v || (h.e >= 0 && b.edge_cnt !== 6'(h.e))) begin
                    errors++;
                    $display("FAIL strobe c=%0d got=%b edge=%0d exp=%b edge=%0d", c, obs, b.edge_cnt, h.v, h.e);
                end
            end else if (obs !== 5'b0) begin
                errors++;
                $display("FAIL unexpected_strobe c=%0d got=%b exp=00000", c, obs);
            end
            if (c < cdone && !(gl && c > ce)) begin
                checks++;
                if (b.edge_cnt !== 6'(c % ps) || b.dat_samp_en !== 1'b1) begin
                    errors++;
                    $display("FAIL edge_cnt c=%0d got=%0d/%b exp=%0d/1", c, b.edge_cnt, b.dat_samp_en, c % ps);
                end
            end
            if (gl && c == ce + 1) begin
                checks++;
                if (b.dat_samp_en !== 1'b0 || b.edge_cnt !== 6'd0) begin
                    errors++;
                    $display("FAIL glitch_idle got=%b/%0d exp=0/0", b.dat_samp_en, b.edge_cnt);
                end
            end
            bi            = c / ps;
            b.strt_glitch = (c == ce) ? gl : !gl;
            b.par_err     = (c == 9 * ps + ce) ? perr : !perr;
            b.stp_err     = (c == nb * ps + ce) ? serr : !serr;
            if (gl) b.RX_IN = c >= 1;
            else if (c == cdone) b.RX_IN = !b2b;
            else if (bi == 0) b.RX_IN = 1'b0;
            else if (bi <= 8) b.RX_IN = d[bi-1];
            else if (bi == 9 && pe) b.RX_IN = ^d;
            else b.RX_IN = 1'b1;
            b.sampled_bit = b.RX_IN;
            if (c == 1) begin
                b.Prescale = (ps == 32) ? 6'd8 : 6'd32;
                b.PAR_EN   = !pe;
            end
            if (c == cdone) begin
                b.Prescale = 6'(nps);
                b.PAR_EN   = npe;
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got=%0d exp=0", q.size());
            q.delete();
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            checks++;
            if (strobes() !== 5'b0 || b.dat_samp_en !== 1'b0) begin
                errors++;
                $display("FAIL idle got=%b/%b exp=00000/0", strobes(), b.dat_samp_en);
            end
        end
    endtask

    task automatic check_flags(input bit par, input bit stp);
        checks++;
        if (b.PAR_ERR_FLAG !== par || b.STP_ERR_FLAG !== stp) begin
            errors++;
            $display("FAIL flags got=%b%b exp=%b%b", b.PAR_ERR_FLAG, b.STP_ERR_FLAG, par, stp);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({b.dat_samp_en, strobes(), b.edge_cnt, b.PAR_ERR_FLAG, b.STP_ERR_FLAG} !== 14'b0) begin
            errors++;
            $display("FAIL reset got=%b exp=0", {b.dat_samp_en, strobes(), b.edge_cnt});
        end
        RST = 1'b1;
        idle_check(4);
    endtask

    task automatic test_frame_p8();
        start(8, 0);
        frame(8, 0, 8'hA5, 0, 0, 0, 0, 8, 0, -1);
        @(posedge CLK); #1;
        check_flags(0, 0);
    endtask

    task automatic test_parity();
        start(16, 1);
        frame(16, 1, 8'h3C, 0, 0, 0, 0, 16, 1, -1);
        @(posedge CLK); #1;
        check_flags(0, 0);
        start(16, 1);
        frame(16, 1, 8'h3C, 0, 1, 0, 0, 16, 1, -1);
        @(posedge CLK); #1;
        check_flags(FLAGS, 0);
    endtask

    task automatic test_stop_err();
        start(8, 0);
        frame(8, 0, 8'h81, 0, 0, 1, 0, 8, 0, -1);
        @(posedge CLK); #1;
        check_flags(FLAGS, FLAGS);
        start(8, 0);
        frame(8, 0, 8'h7E, 0, 0, 0, 0, 8, 0, -1);
        @(posedge CLK); #1;
        check_flags(0, 0);
    endtask

    task automatic test_glitch();
        start(8, 0);
        frame(8, 0, 8'h00, 1, 0, 0, 0, 8, 0, -1);
        idle_check(24);
    endtask

    task automatic test_reset_mid();
        start(8, 0);
        frame(8, 0, 8'h96, 0, 0, 0, 0, 8, 0, 20);
        b.RX_IN = 1'b1;
        #2 RST = 1'b0;
        #1;
        checks++;
        if ({b.dat_samp_en, strobes(), b.edge_cnt} !== 12'b0) begin
            errors++;
            $display("FAIL reset_mid got=%b exp=0", {b.dat_samp_en, strobes(), b.edge_cnt});
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        idle_check(20);
        start(8, 0);
        frame(8, 0, 8'h0F, 0, 0, 0, 0, 8, 0, -1);
    endtask

    task automatic test_back_to_back();
        start(32, 1);
        frame(32, 1, 8'h5A, 0, 0, 0, 1, 32, 1, -1);
        frame(32, 1, 8'hC3, 0, 0, 0, 0, 8, 0, -1);
        idle_check(4);
    endtask

    initial begin
        b.RX_IN       = 1'b1;
        b.PAR_EN      = 1'b0;
        b.Prescale    = 6'd8;
        b.sampled_bit = 1'b1;
        b.par_err     = 1'b0;
        b.strt_glitch = 1'b0;
        b.stp_err     = 1'b0;
        test_reset();
        test_frame_p8();
        test_parity();
        test_stop_err();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
